mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the microcontroller's single-port instruction/data memory between the core's instruction-fetch unit and its load/store unit.
- Sits between the RISC-V core and the memory macro.
- Serialises accesses: one transaction outstanding at a time.
- Load/store has fixed priority; a starvation counter guarantees fetch forward progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal 1..7).
- STARVE_MAX, 4, consecutive lost contentions after which fetch wins (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DW  fetch data
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_be  in  DW/8  store byte enables
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  load/store granted this cycle
- ls_rvalid  out  1  load data / store ack (1-cycle pulse)
- ls_rdata  out  DW  load data; 0 on store ack
- mem_en  out  1  memory access strobe (1 cycle)
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE, starve counter=0.
  - mem_en/mem_we/mem_be/mem_addr/mem_wdata = 0.
  - if_rvalid/ls_rvalid = 0; if_rdata/ls_rdata = 0.
  - if_gnt/ls_gnt forced 0 while reset is high; busy = 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Grant window: state IDLE or RESP only.
  - gnt is combinational from req and state.
  - At most one gnt per cycle.
  - Request fields are captured into the mem_* registers on the granting edge.
- Arbitration:
  - Only ls_req: ls wins.
  - Only if_req: fetch wins.
  - Both: ls wins unless starve counter == STARVE_MAX, in which case fetch wins.
  - Starve counter increments on each grant to ls while if_req=1.
  - Counter clears on any fetch grant and saturates at STARVE_MAX.
- Requester rules:
  - Holds req and its fields stable until gnt.
  - req still high in the cycle after gnt is a new request.
- Timeline, grant in cycle T:
  - T: gnt=1; next state ACCESS.
  - T+1 (ACCESS): mem_en=1 with captured we/be/addr/wdata; next state WAIT; latency counter loads MEM_LAT.
  - WAIT lasts MEM_LAT cycles: T+2 .. T+1+MEM_LAT.
  - mem_rdata is sampled at the end of cycle T+1+MEM_LAT.
  - T+2+MEM_LAT (RESP): owner's rvalid=1 for one cycle, with rdata = sampled word (reads) or 0 (stores); the other requester's rvalid stays 0.
  - RESP → ACCESS if a grant is issued, else → IDLE.
  - Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- mem_en deasserts after ACCESS. mem_addr/we/be/wdata hold their last value until the next ACCESS.
- rdata outputs hold until the next RESP for that port.
- mem_rdata is ignored outside the sampling cycle.
- Reset mid-transaction: the in-flight access is abandoned; no rvalid is produced; FSM restarts in IDLE.
- Fetch never asserts a write: mem_we=0 and mem_be=all-ones for fetches.

Test Plan:
- Single fetch, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x100 at cycle 0; memory returns 0xDEADBEEF in cycle 2.
  - Required: if_gnt cycle 0; mem_en=1, mem_addr=0x100, mem_we=0 in cycle 1; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 3 only; busy cycles 1-3.
- Store, MEM_LAT=1:
  - Stimulus: ls_req, ls_we=1, ls_be=4'b0011, ls_addr=0x2000, ls_wdata=0x12345678.
  - Required: mem_en/mem_we=1 with matching be/addr/wdata one cycle after gnt; ls_rvalid=1, ls_rdata=0 two cycles later; if_rvalid stays 0.
- Contention, STARVE_MAX=4:
  - Stimulus: if_req and ls_req both held high.
  - Required: grants go ls, ls, ls, ls, fetch, ls…; fetch granted on the 5th grant.
  - Required: grants land in RESP cycles, spaced exactly 3 cycles apart.
- MEM_LAT=3 load:
  - Stimulus: ls load granted at cycle 0; mem_rdata=0xA5A5A5A5 only in cycle 4.
  - Required: mem_en in cycle 1; ls_rvalid with 0xA5A5A5A5 in cycle 5.
- Reset mid-WAIT:
  - Stimulus: assert reset during cycle 2 of an MEM_LAT=3 fetch.
  - Required: all outputs to reset values immediately; no if_rvalid ever for that fetch; a new request after release is granted in its first cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// One access in flight; load/store has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [2:0] LAT  = 3'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve;
  logic [2:0] lat_cnt;
  logic       owner_ls;
  logic       win;
  logic       fetch_pri;
  logic       last_wait;

  // Grants are only offered while no access is in flight (IDLE, or the RESP cycle of the previous one).
  always_comb begin
    win       = !reset && (state == IDLE || state == RESP);
    fetch_pri = (starve == SMAX);
    if_gnt    = win && if_req && (!ls_req || fetch_pri);
    ls_gnt    = win && ls_req && !(if_req && fetch_pri);
    last_wait = (state == WAIT) && (lat_cnt == 3'd1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_gnt || ls_gnt) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (lat_cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = (if_gnt || ls_gnt) ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner_ls  <= 1'b0;
      starve    <= 4'd0;
    end else begin
      mem_en <= if_gnt || ls_gnt;
      if (if_gnt) begin
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        owner_ls  <= 1'b0;
        starve    <= 4'd0;
      end else if (ls_gnt) begin
        mem_we    <= ls_we;
        mem_be    <= ls_be;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        owner_ls  <= 1'b1;
        if (if_req && starve != SMAX) starve <= starve + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                lat_cnt <= 3'd0;
    else if (state == ACCESS) lat_cnt <= LAT;
    else if (state == WAIT)   lat_cnt <= lat_cnt - 3'd1;
  end

  // mem_rdata is only looked at in the final WAIT cycle; stores return a zero word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (last_wait) begin
        if (owner_ls) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_we ? '0 : mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter at MEM_LAT=1 (dut0) and MEM_LAT=3 (dut1)
// Timestamp-based transaction model plus directed literal checks from hand-derived timelines.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], if_req[2], if_gnt[2], if_rvalid[2];
  logic        ls_req[2], ls_we[2], ls_gnt[2], ls_rvalid[2];
  logic        mem_en[2], mem_we[2], busy[2];
  logic [31:0] if_addr[2], if_rdata[2], ls_addr[2], ls_wdata[2], ls_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [3:0]  ls_be[2], mem_be[2];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut0 (
    .clk(clk), .reset(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_be(ls_be[0]), .ls_addr(ls_addr[0]),
    .ls_wdata(ls_wdata[0]), .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_be(ls_be[1]), .ls_addr(ls_addr[1]),
    .ls_wdata(ls_wdata[1]), .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: each transaction is a set of timestamps derived from its grant cycle.
  int          next_ok[2], starve[2], en_at[2], rv_at[2], last_g[2];
  logic        rv_ls[2], c_we[2], c_st[2], gl_if[2], gl_ls[2];
  logic [3:0]  c_be[2];
  logic [31:0] rv_data[2], e_if_rdata[2], e_ls_rdata[2], c_addr[2], c_wdata[2];
  logic [31:0] ref_mem[2][256];
  logic [31:0] bmem[2][256];
  int          sched_at[2];
  logic [7:0]  sched_idx[2];
  int          m_lat;
  logic        m_eig, m_elg;

  int   gc[16];
  logic gf[16];
  int   ng;
  int   dens;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic void model_reset(input int k);
    next_ok[k] = 0;  starve[k] = 0;  en_at[k] = -1;  rv_at[k] = -1;  last_g[k] = -100;
    rv_ls[k] = 1'b0; rv_data[k] = '0; e_if_rdata[k] = '0; e_ls_rdata[k] = '0;
    c_we[k] = 1'b0;  c_st[k] = 1'b0;  c_be[k] = '0;  c_addr[k] = '0;  c_wdata[k] = '0;
    gl_if[k] = 1'b0; gl_ls[k] = 1'b0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_lat = lat_of(k);
      if (rst[k]) begin
        chk("rst_if_gnt", k, 32'(if_gnt[k]), 0);
        chk("rst_ls_gnt", k, 32'(ls_gnt[k]), 0);
        chk("rst_mem_en", k, 32'(mem_en[k]), 0);
        chk("rst_mem_we", k, 32'(mem_we[k]), 0);
        chk("rst_mem_be", k, 32'(mem_be[k]), 0);
        chk("rst_mem_addr", k, mem_addr[k], 0);
        chk("rst_mem_wdata", k, mem_wdata[k], 0);
        chk("rst_if_rvalid", k, 32'(if_rvalid[k]), 0);
        chk("rst_ls_rvalid", k, 32'(ls_rvalid[k]), 0);
        chk("rst_if_rdata", k, if_rdata[k], 0);
        chk("rst_ls_rdata", k, ls_rdata[k], 0);
        chk("rst_busy", k, 32'(busy[k]), 0);
        model_reset(k);
      end else begin
        m_eig = (cyc >= next_ok[k]) && if_req[k] && (!ls_req[k] || starve[k] == SMAX);
        m_elg = (cyc >= next_ok[k]) && ls_req[k] && !m_eig;
        if (cyc == rv_at[k]) begin
          if (rv_ls[k]) e_ls_rdata[k] = rv_data[k];
          else          e_if_rdata[k] = rv_data[k];
        end
        chk("if_gnt", k, 32'(if_gnt[k]), 32'(m_eig));
        chk("ls_gnt", k, 32'(ls_gnt[k]), 32'(m_elg));
        chk("mem_en", k, 32'(mem_en[k]), 32'(cyc == en_at[k]));
        chk("mem_we", k, 32'(mem_we[k]), 32'(c_we[k]));
        chk("mem_be", k, 32'(mem_be[k]), 32'(c_be[k]));
        chk("mem_addr", k, mem_addr[k], c_addr[k]);
        if (cyc == en_at[k] && c_st[k]) chk("mem_wdata", k, mem_wdata[k], c_wdata[k]);
        chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(cyc == rv_at[k] && !rv_ls[k]));
        chk("ls_rvalid", k, 32'(ls_rvalid[k]), 32'(cyc == rv_at[k] && rv_ls[k]));
        chk("if_rdata", k, if_rdata[k], e_if_rdata[k]);
        chk("ls_rdata", k, ls_rdata[k], e_ls_rdata[k]);
        chk("busy", k, 32'(busy[k]), 32'(cyc > last_g[k] && cyc <= last_g[k] + m_lat + 2));
        if (m_eig || m_elg) begin
          en_at[k] = cyc + 1;  rv_at[k] = cyc + m_lat + 2;
          next_ok[k] = cyc + m_lat + 2;  last_g[k] = cyc;
          rv_ls[k] = m_elg;
        end
        if (m_eig) begin
          starve[k] = 0;
          c_we[k] = 1'b0;  c_st[k] = 1'b0;  c_be[k] = 4'hF;  c_addr[k] = if_addr[k];
          rv_data[k] = ref_mem[k][if_addr[k][9:2]];
        end else if (m_elg) begin
          if (if_req[k] && starve[k] < SMAX) starve[k]++;
          c_we[k] = ls_we[k];  c_st[k] = ls_we[k];  c_be[k] = ls_be[k];
          c_addr[k] = ls_addr[k];  c_wdata[k] = ls_wdata[k];
          if (ls_we[k]) begin
            ref_mem[k][ls_addr[k][9:2]] = merge(ref_mem[k][ls_addr[k][9:2]], ls_wdata[k], ls_be[k]);
            rv_data[k] = '0;
          end else begin
            rv_data[k] = ref_mem[k][ls_addr[k][9:2]];
          end
        end
        gl_if[k] = if_gnt[k];
        gl_ls[k] = ls_gnt[k];
      end
    end
  end

  // Memory macro stand-in: word valid only in the sampling cycle, noise otherwise.
  task automatic respond;
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && !rst[k]) begin
        if (mem_we[k])
          bmem[k][mem_addr[k][9:2]] = merge(bmem[k][mem_addr[k][9:2]], mem_wdata[k], mem_be[k]);
        else begin
          sched_at[k]  = cyc + lat_of(k);
          sched_idx[k] = mem_addr[k][9:2];
        end
      end
      mem_rdata[k] = (cyc == sched_at[k]) ? bmem[k][sched_idx[k]] : $urandom;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    respond();
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic poke(input int k, input logic [31:0] a, input logic [31:0] v);
    bmem[k][a[9:2]]    = v;
    ref_mem[k][a[9:2]] = v;
  endtask

  task automatic idle_inputs(input int k);
    if_req[k] = 1'b0; ls_req[k] = 1'b0; ls_we[k] = 1'b0; ls_be[k] = '0;
    if_addr[k] = '0;  ls_addr[k] = '0;  ls_wdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    step(); idle_inputs(k); rst[k] = 1'b1; neg();
    step(); rst[k] = 1'b0; neg();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      idle_inputs(k);
      mem_rdata[k] = '0;
      sched_at[k] = -1;
      sched_idx[k] = '0;
      model_reset(k);
      for (int i = 0; i < 256; i++) begin
        bmem[k][i] = $urandom;
        ref_mem[k][i] = bmem[k][i];
      end
    end
    for (int i = 0; i < 16; i++) begin gc[i] = 0; gf[i] = 1'b0; end
    step(); neg();
    step(); rst[0] = 1'b0; rst[1] = 1'b0; neg();

    // single fetch, MEM_LAT=1
    poke(0, 32'h100, 32'hDEADBEEF);
    step(); if_req[0] = 1'b1; if_addr[0] = 32'h100; neg();
    chk("t1_gnt", 0, 32'(if_gnt[0]), 1);
    chk("t1_busy0", 0, 32'(busy[0]), 0);
    step(); if_req[0] = 1'b0; neg();
    chk("t1_en", 0, 32'(mem_en[0]), 1);
    chk("t1_addr", 0, mem_addr[0], 32'h100);
    chk("t1_we", 0, 32'(mem_we[0]), 0);
    chk("t1_busy1", 0, 32'(busy[0]), 1);
    step(); neg();
    chk("t1_en2", 0, 32'(mem_en[0]), 0);
    chk("t1_rv2", 0, 32'(if_rvalid[0]), 0);
    step(); neg();
    chk("t1_rv3", 0, 32'(if_rvalid[0]), 1);
    chk("t1_rdata", 0, if_rdata[0], 32'hDEADBEEF);
    chk("t1_busy3", 0, 32'(busy[0]), 1);
    step(); neg();
    chk("t1_rv4", 0, 32'(if_rvalid[0]), 0);
    chk("t1_busy4", 0, 32'(busy[0]), 0);
    chk("t1_hold", 0, if_rdata[0], 32'hDEADBEEF);

    // store, MEM_LAT=1
    step(); ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_be[0] = 4'b0011;
    ls_addr[0] = 32'h2000; ls_wdata[0] = 32'h12345678; neg();
    chk("t2_gnt", 0, 32'(ls_gnt[0]), 1);
    step(); ls_req[0] = 1'b0; neg();
    chk("t2_en", 0, 32'(mem_en[0]), 1);
    chk("t2_we", 0, 32'(mem_we[0]), 1);
    chk("t2_be", 0, 32'(mem_be[0]), 32'h3);
    chk("t2_addr", 0, mem_addr[0], 32'h2000);
    chk("t2_wdata", 0, mem_wdata[0], 32'h12345678);
    step(); neg();
    step(); neg();
    chk("t2_rv", 0, 32'(ls_rvalid[0]), 1);
    chk("t2_rdata", 0, ls_rdata[0], 32'h0);
    chk("t2_if_rv", 0, 32'(if_rvalid[0]), 0);

    // contention with both requests held
    do_reset(0);
    step(); if_req[0] = 1'b1; if_addr[0] = 32'h300;
    ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_be[0] = 4'hF; ls_addr[0] = 32'h44;
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      neg();
      if ((if_gnt[0] || ls_gnt[0]) && ng < 16) begin gc[ng] = cyc; gf[ng] = if_gnt[0]; ng++; end
    end
    chk("t3_count", 0, 32'(ng >= 6), 1);
    for (int i = 0; i < 6; i++) chk("t3_owner", 0, 32'(gf[i]), (i == 4) ? 32'd1 : 32'd0);
    for (int i = 1; i < 6; i++) chk("t3_gap", 0, gc[i] - gc[i-1], 3);
    step(); idle_inputs(0);
    repeat (4) begin step(); neg(); end

    // MEM_LAT=3 load
    do_reset(1);
    poke(1, 32'h40, 32'hA5A5A5A5);
    step(); ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_be[1] = 4'hF; ls_addr[1] = 32'h40; neg();
    chk("t4_gnt", 1, 32'(ls_gnt[1]), 1);
    step(); ls_req[1] = 1'b0; neg();
    chk("t4_en", 1, 32'(mem_en[1]), 1);
    for (int i = 2; i <= 4; i++) begin step(); neg(); chk("t4_norv", 1, 32'(ls_rvalid[1]), 0); end
    step(); neg();
    chk("t4_rv", 1, 32'(ls_rvalid[1]), 1);
    chk("t4_rdata", 1, ls_rdata[1], 32'hA5A5A5A5);

    // reset in the middle of a MEM_LAT=3 fetch
    do_reset(1);
    step(); if_req[1] = 1'b1; if_addr[1] = 32'h80; neg();
    chk("t5_gnt", 1, 32'(if_gnt[1]), 1);
    step(); if_req[1] = 1'b0; neg();
    step(); rst[1] = 1'b1; neg();
    chk("t5_busy", 1, 32'(busy[1]), 0);
    chk("t5_en", 1, 32'(mem_en[1]), 0);
    chk("t5_addr", 1, mem_addr[1], 0);
    step(); rst[1] = 1'b0; neg();
    step(); ls_req[1] = 1'b1; ls_addr[1] = 32'h84; ls_be[1] = 4'hF; neg();
    chk("t5_newgnt", 1, 32'(ls_gnt[1]), 1);
    step(); ls_req[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin neg(); chk("t5_no_if_rv", 1, 32'(if_rvalid[1]), 0); step(); end
    neg();

    // randomized traffic on both instances
    dens = 50;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (n % 250 == 0) dens = ($urandom_range(0, 2) == 0) ? 30 : ($urandom_range(0, 1) ? 70 : 100);
      for (int k = 0; k < 2; k++) begin
        if (!(if_req[k] && !gl_if[k])) begin
          if_req[k]  = ($urandom_range(0, 99) < dens);
          if_addr[k] = $urandom;
        end
        if (!(ls_req[k] && !gl_ls[k])) begin
          ls_req[k]   = ($urandom_range(0, 99) < dens);
          ls_we[k]    = $urandom_range(0, 1) == 1;
          ls_be[k]    = 4'($urandom);
          ls_addr[k]  = $urandom;
          ls_wdata[k] = $urandom;
        end
      end
      neg();
    end
    step(); idle_inputs(0); idle_inputs(1);
    repeat (10) begin neg(); step(); end
    neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
